// File: rtl/store_data_formatter_pkg.sv
// Shared encodings for the store data formatter.
// Holds the store size codes and the FSM state codes.
// No logic; imported by the interface users, the lane mask and the top.
package store_fmt_pkg;

    // Store size as carried on req_size: bytes = 1 << size
    typedef enum logic [1:0] {
        SZ_BYTE  = 2'b00,
        SZ_HALF  = 2'b01,
        SZ_WORD  = 2'b10,
        SZ_DWORD = 2'b11
    } size_e;

    // READ and WAIT are only reachable when RMW=1
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WRITE = 2'b01,
        ST_READ  = 2'b10,
        ST_WAIT  = 2'b11
    } state_e;

endpackage

// File: rtl/store_data_formatter_if.sv
// Bus bundles for the store data formatter.
// store_req_if: execute-stage store request plus status (misalign_err, busy).
// store_mem_if: data memory command port with read-data return for RMW mode.
interface store_req_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic [DATA_W-1:0] req_data;
    logic              misalign_err;
    logic              busy;

    // master: the store issuer
    modport master (
        output req_valid, req_addr, req_size, req_data,
        input  req_ready, misalign_err, busy
    );

    // slave: the formatter
    modport slave (
        input  req_valid, req_addr, req_size, req_data,
        output req_ready, misalign_err, busy
    );
endinterface

interface store_mem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int NB = DATA_W / 8;

    logic              mem_valid;
    logic              mem_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [NB-1:0]     mem_be;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    // master: the formatter issuing commands
    modport master (
        output mem_valid, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    // slave: the memory
    modport slave (
        input  mem_valid, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/store_data_formatter_lane_mask.sv
// Combinational lane alignment: replicated store data, byte enables, illegal flag.
// Ports: i_lane (addr low bits), i_size, i_data -> o_data, o_be, o_illegal.
// Zero latency; no handshake.
module store_lane_mask
    import store_fmt_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int NB     = DATA_W / 8,
    localparam int LB     = $clog2(NB)
) (
    input  logic [LB-1:0]     i_lane,
    input  logic [1:0]        i_size,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data,
    output logic [NB-1:0]     o_be,
    output logic              o_illegal
);

    logic [3:0]    w_bytes;
    logic [15:0]   w_mask;
    logic [LB-1:0] w_lane_off;

    always_comb begin
        w_bytes = 4'd1 << i_size;
        // Contiguous run of `bytes` ones shifted up to the starting lane
        w_mask  = ((16'd1 << w_bytes) - 16'd1) << i_lane;
        o_be    = w_mask[NB-1:0];
        // Lane bits below the access size must be zero for natural alignment
        w_lane_off = i_lane & LB'(w_bytes - 4'd1);
        o_illegal  = (w_bytes > 4'(NB)) || (w_lane_off != '0);
    end

    // Replicate the low `bytes` bytes to every lane; be selects the live ones
    always_comb begin
        o_data = i_data;
        unique case (size_e'(i_size))
            SZ_BYTE:  o_data = {NB{i_data[7:0]}};
            SZ_HALF:  o_data = {(NB/2){i_data[15:0]}};
            SZ_WORD:  o_data = {(NB/4){i_data[31:0]}};
            default:  o_data = i_data;
        endcase
    end

endmodule

// File: rtl/store_data_formatter.sv
// Store path from execute stage to data memory: align, byte-enable, optional read-merge-write.
// Ports: clk, reset (async high), req (store_req_if.slave), mem (store_mem_if.master).
// Direct: 1 cycle accept->command, 1 store/cycle. RMW: read, wait rdata, full write; command held until mem_ready.
module store_data_formatter
    import store_fmt_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int RMW    = 0
) (
    input  logic        clk,
    input  logic        reset,
    store_req_if.slave  req,
    store_mem_if.master mem
);

    localparam int NB     = DATA_W / 8;
    localparam int LB     = $clog2(NB);
    localparam bit DIRECT = (RMW == 0);

    state_e            r_state, w_state_nxt;
    logic              r_mem_valid, w_mem_valid_nxt;
    logic              r_mem_we, w_mem_we_nxt;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic [NB-1:0]     r_mem_be, w_mem_be_nxt;
    logic              r_misalign_err, w_misalign_err_nxt;
    // Merge source for RMW: aligned store data and its byte enables
    logic [DATA_W-1:0] r_data, w_data_nxt;
    logic [NB-1:0]     r_be, w_be_nxt;

    logic [DATA_W-1:0] w_lane_data;
    logic [NB-1:0]     w_lane_be;
    logic              w_illegal;
    logic              w_req_ready;
    logic              w_accept;
    logic [DATA_W-1:0] w_merged;

    store_lane_mask #(
        .DATA_W (DATA_W)
    ) u_lane_mask (
        .i_lane    (req.req_addr[LB-1:0]),
        .i_size    (req.req_size),
        .i_data    (req.req_data),
        .o_data    (w_lane_data),
        .o_be      (w_lane_be),
        .o_illegal (w_illegal)
    );

    // Direct mode can take the next store in the cycle the current write completes
    assign w_req_ready = (r_state == ST_IDLE) ||
                         (DIRECT && (r_state == ST_WRITE) && mem.mem_ready);
    assign w_accept    = req.req_valid && w_req_ready;

    always_comb begin
        w_merged = mem.mem_rdata;
        for (int i = 0; i < NB; i++) begin
            if (r_be[i]) begin
                w_merged[i*8 +: 8] = r_data[i*8 +: 8];
            end
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_mem_valid_nxt    = r_mem_valid;
        w_mem_we_nxt       = r_mem_we;
        w_mem_addr_nxt     = r_mem_addr;
        w_mem_wdata_nxt    = r_mem_wdata;
        w_mem_be_nxt       = r_mem_be;
        w_data_nxt         = r_data;
        w_be_nxt           = r_be;
        w_misalign_err_nxt = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
            end
            ST_WRITE: begin
                if (mem.mem_ready) begin
                    w_state_nxt     = ST_IDLE;
                    w_mem_valid_nxt = 1'b0;
                    w_mem_we_nxt    = 1'b0;
                end
            end
            ST_READ: begin
                if (mem.mem_ready) begin
                    w_state_nxt     = ST_WAIT;
                    w_mem_valid_nxt = 1'b0;
                end
            end
            ST_WAIT: begin
                if (mem.mem_rvalid) begin
                    w_state_nxt     = ST_WRITE;
                    w_mem_valid_nxt = 1'b1;
                    w_mem_we_nxt    = 1'b1;
                    w_mem_wdata_nxt = w_merged;
                    w_mem_be_nxt    = '1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Accept only happens in IDLE or a completing direct WRITE, both of
        // which have already steered next state to IDLE above.
        if (w_accept) begin
            if (w_illegal) begin
                w_misalign_err_nxt = 1'b1;
            end else if (DIRECT) begin
                w_state_nxt     = ST_WRITE;
                w_mem_valid_nxt = 1'b1;
                w_mem_we_nxt    = 1'b1;
                w_mem_addr_nxt  = {req.req_addr[ADDR_W-1:LB], LB'(0)};
                w_mem_wdata_nxt = w_lane_data;
                w_mem_be_nxt    = w_lane_be;
            end else begin
                w_state_nxt     = ST_READ;
                w_mem_valid_nxt = 1'b1;
                w_mem_we_nxt    = 1'b0;
                w_mem_addr_nxt  = {req.req_addr[ADDR_W-1:LB], LB'(0)};
                w_mem_be_nxt    = '1;
                w_data_nxt      = w_lane_data;
                w_be_nxt        = w_lane_be;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_mem_valid    <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_mem_be       <= '0;
            r_misalign_err <= 1'b0;
            r_data         <= '0;
            r_be           <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_mem_valid    <= w_mem_valid_nxt;
            r_mem_we       <= w_mem_we_nxt;
            r_mem_addr     <= w_mem_addr_nxt;
            r_mem_wdata    <= w_mem_wdata_nxt;
            r_mem_be       <= w_mem_be_nxt;
            r_misalign_err <= w_misalign_err_nxt;
            r_data         <= w_data_nxt;
            r_be           <= w_be_nxt;
        end
    end

    assign req.req_ready    = w_req_ready;
    assign req.misalign_err = r_misalign_err;
    assign req.busy         = (r_state != ST_IDLE);
    assign mem.mem_valid    = r_mem_valid;
    assign mem.mem_we       = r_mem_we;
    assign mem.mem_addr     = r_mem_addr;
    assign mem.mem_wdata    = r_mem_wdata;
    assign mem.mem_be       = r_mem_be;

endmodule

// File: tb/tb_store_data_formatter.sv
// Directed bench for store_data_formatter in three configurations:
// 32-bit direct, 64-bit read-merge-write, 64-bit direct.
// Inputs driven 1 time unit after the rising edge; outputs sampled there too.
module tb_store_data_formatter;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    store_req_if #(.ADDR_W(32), .DATA_W(32)) rq32 ();
    store_mem_if #(.ADDR_W(32), .DATA_W(32)) mm32 ();
    store_req_if #(.ADDR_W(32), .DATA_W(64)) rq64r ();
    store_mem_if #(.ADDR_W(32), .DATA_W(64)) mm64r ();
    store_req_if #(.ADDR_W(32), .DATA_W(64)) rq64d ();
    store_mem_if #(.ADDR_W(32), .DATA_W(64)) mm64d ();

    store_data_formatter #(.DATA_W(32), .ADDR_W(32), .RMW(0)) u_dut32 (
        .clk(clk), .reset(reset), .req(rq32.slave), .mem(mm32.master));
    store_data_formatter #(.DATA_W(64), .ADDR_W(32), .RMW(1)) u_dut64r (
        .clk(clk), .reset(reset), .req(rq64r.slave), .mem(mm64r.master));
    store_data_formatter #(.DATA_W(64), .ADDR_W(32), .RMW(0)) u_dut64d (
        .clk(clk), .reset(reset), .req(rq64d.slave), .mem(mm64d.master));

    // Write-handshake logs
    logic [31:0] wr32_addr[$];
    int          wr64r_n;
    initial wr64r_n = 0;
    always @(posedge clk) begin
        if (!reset && mm32.mem_valid && mm32.mem_ready && mm32.mem_we)
            wr32_addr.push_back(mm32.mem_addr);
        if (!reset && mm64r.mem_valid && mm64r.mem_ready && mm64r.mem_we)
            wr64r_n++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        rq32.req_valid = 0;  rq32.req_addr = 0;  rq32.req_size = 0;  rq32.req_data = 0;
        rq64r.req_valid = 0; rq64r.req_addr = 0; rq64r.req_size = 0; rq64r.req_data = 0;
        rq64d.req_valid = 0; rq64d.req_addr = 0; rq64d.req_size = 0; rq64d.req_data = 0;
        mm32.mem_ready = 0;  mm32.mem_rvalid = 0;  mm32.mem_rdata = 0;
        mm64r.mem_ready = 0; mm64r.mem_rvalid = 0; mm64r.mem_rdata = 0;
        mm64d.mem_ready = 0; mm64d.mem_rvalid = 0; mm64d.mem_rdata = 0;
        tick();
        tick();
        check("rst_valid",     mm32.mem_valid, 0);
        check("rst_err",       rq32.misalign_err, 0);
        check("rst_busy",      rq32.busy, 0);
        check("rst_ready",     rq32.req_ready, 1);
        reset = 1'b0;
        tick();

        // ---- 32-bit direct: byte store, upper data bits must be ignored
        mm32.mem_ready = 1;
        rq32.req_valid = 1; rq32.req_addr = 32'h1003; rq32.req_size = 2'b00; rq32.req_data = 32'hFFFF12AB;
        tick();
        rq32.req_valid = 0;
        check("b_valid", mm32.mem_valid, 1);
        check("b_we",    mm32.mem_we, 1);
        check("b_addr",  mm32.mem_addr, 32'h1000);
        check("b_wdata", mm32.mem_wdata, 32'hABABABAB);
        check("b_be",    mm32.mem_be, 4'b1000);
        tick();
        check("b_done",  mm32.mem_valid, 0);
        check("b_idle",  rq32.busy, 0);

        // ---- misaligned half
        rq32.req_valid = 1; rq32.req_addr = 32'h2001; rq32.req_size = 2'b01; rq32.req_data = 32'h1234;
        tick();
        rq32.req_valid = 0;
        check("mh_err",   rq32.misalign_err, 1);
        check("mh_valid", mm32.mem_valid, 0);
        tick();
        check("mh_pulse", rq32.misalign_err, 0);

        // ---- dword on a 32-bit memory
        rq32.req_valid = 1; rq32.req_addr = 32'h2000; rq32.req_size = 2'b11;
        tick();
        rq32.req_valid = 0;
        check("dw32_err",   rq32.misalign_err, 1);
        check("dw32_valid", mm32.mem_valid, 0);
        tick();

        // ---- back-to-back words with memory stall
        mm32.mem_ready = 0;
        rq32.req_valid = 1; rq32.req_addr = 32'h0; rq32.req_size = 2'b10; rq32.req_data = 32'h11111111;
        tick();
        rq32.req_addr = 32'h4; rq32.req_data = 32'h22222222;
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", mm32.mem_valid, 1);
            check("stall_addr",  mm32.mem_addr, 32'h0);
            check("stall_wdata", mm32.mem_wdata, 32'h11111111);
            check("stall_ready", rq32.req_ready, 0);
            if (i < 2) tick();
        end
        mm32.mem_ready = 1;
        #1;
        check("b2b_ready", rq32.req_ready, 1);
        tick();
        rq32.req_valid = 0;
        check("b2b_valid", mm32.mem_valid, 1);
        check("b2b_addr",  mm32.mem_addr, 32'h4);
        check("b2b_wdata", mm32.mem_wdata, 32'h22222222);
        check("b2b_be",    mm32.mem_be, 4'hF);
        tick();
        check("b2b_done",  mm32.mem_valid, 0);
        check("wr_count",  wr32_addr.size(), 3);
        check("wr_order0", wr32_addr[1], 32'h0);
        check("wr_order1", wr32_addr[2], 32'h4);

        // ---- 64-bit RMW: half 0xBEEF at 0x106
        rq64r.req_valid = 1; rq64r.req_addr = 32'h106; rq64r.req_size = 2'b01; rq64r.req_data = 64'hBEEF;
        tick();
        rq64r.req_valid = 0;
        check("rd_valid", mm64r.mem_valid, 1);
        check("rd_we",    mm64r.mem_we, 0);
        check("rd_addr",  mm64r.mem_addr, 32'h100);
        check("rd_be",    mm64r.mem_be, 8'hFF);
        check("rd_ready", rq64r.req_ready, 0);
        check("rd_busy",  rq64r.busy, 1);
        mm64r.mem_ready = 1;
        tick();
        mm64r.mem_ready = 0;
        check("wait_valid", mm64r.mem_valid, 0);
        tick();
        mm64r.mem_rvalid = 1; mm64r.mem_rdata = 64'h1122334455667788;
        tick();
        mm64r.mem_rvalid = 0;
        check("rmw_valid", mm64r.mem_valid, 1);
        check("rmw_we",    mm64r.mem_we, 1);
        check("rmw_addr",  mm64r.mem_addr, 32'h100);
        check("rmw_wdata", mm64r.mem_wdata, 64'hBEEF334455667788);
        check("rmw_be",    mm64r.mem_be, 8'hFF);
        mm64r.mem_ready = 1;
        tick();
        check("rmw_done", mm64r.mem_valid, 0);
        check("rmw_idle", rq64r.busy, 0);
        // stray read data while idle
        mm64r.mem_rvalid = 1;
        tick();
        mm64r.mem_rvalid = 0;
        check("stray_valid", mm64r.mem_valid, 0);
        check("stray_busy",  rq64r.busy, 0);

        // ---- reset during WAIT, response arrives afterwards
        rq64r.req_valid = 1; rq64r.req_addr = 32'h10; rq64r.req_size = 2'b10; rq64r.req_data = 64'hCAFEF00D;
        tick();
        rq64r.req_valid = 0;
        tick();
        mm64r.mem_ready = 0;
        check("w_busy",  rq64r.busy, 1);
        check("w_valid", mm64r.mem_valid, 0);
        reset = 1;
        #2;
        check("ar_busy",  rq64r.busy, 0);
        check("ar_addr",  mm64r.mem_addr, 0);
        check("ar_be",    mm64r.mem_be, 0);
        check("ar_wdata", mm64r.mem_wdata, 0);
        tick();
        reset = 0;
        mm64r.mem_ready = 1;
        mm64r.mem_rvalid = 1; mm64r.mem_rdata = 64'hFFFFFFFFFFFFFFFF;
        tick();
        mm64r.mem_rvalid = 0;
        tick();
        check("pr_valid", mm64r.mem_valid, 0);
        check("pr_busy",  rq64r.busy, 0);
        check("pr_wr_n",  wr64r_n, 1);

        // ---- 64-bit direct
        mm64d.mem_ready = 1;
        rq64d.req_valid = 1; rq64d.req_addr = 32'h8; rq64d.req_size = 2'b11; rq64d.req_data = 64'h0123456789ABCDEF;
        tick();
        rq64d.req_valid = 0;
        check("dw_valid", mm64d.mem_valid, 1);
        check("dw_addr",  mm64d.mem_addr, 32'h8);
        check("dw_be",    mm64d.mem_be, 8'hFF);
        check("dw_wdata", mm64d.mem_wdata, 64'h0123456789ABCDEF);
        tick();
        rq64d.req_valid = 1; rq64d.req_addr = 32'hC; rq64d.req_size = 2'b11;
        tick();
        rq64d.req_valid = 0;
        check("dwm_err",   rq64d.misalign_err, 1);
        check("dwm_valid", mm64d.mem_valid, 0);
        tick();
        // word in upper lanes, then an illegal store taken in the completing write cycle
        rq64d.req_valid = 1; rq64d.req_addr = 32'hC; rq64d.req_size = 2'b10; rq64d.req_data = 64'h55555555DEADBEEF;
        tick();
        rq64d.req_addr = 32'h1; rq64d.req_size = 2'b01;
        check("w64_be",    mm64d.mem_be, 8'hF0);
        check("w64_addr",  mm64d.mem_addr, 32'h8);
        check("w64_wdata", mm64d.mem_wdata, 64'hDEADBEEFDEADBEEF);
        tick();
        rq64d.req_valid = 0;
        check("ilw_err",   rq64d.misalign_err, 1);
        check("ilw_valid", mm64d.mem_valid, 0);
        check("ilw_busy",  rq64d.busy, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
